// File: rtl/cbfp_pkg.sv
// Shared widths and types for the block-floating-point sequencer.
package cbfp_pkg;

   localparam int DATA_WIDTH = 25;
   localparam int OUT_WIDTH  = 13;
   localparam int MAG_WIDTH  = 5;
   localparam int NUM_LANES  = 8;

   typedef logic signed [DATA_WIDTH-1:0] din_lane_t;
   typedef logic signed [OUT_WIDTH-1:0]  dout_lane_t;
   typedef logic [MAG_WIDTH-1:0]         mag_t;

   typedef din_lane_t  din_lanes_t  [0:NUM_LANES-1];
   typedef dout_lane_t dout_lanes_t [0:NUM_LANES-1];
   typedef mag_t       mag_lanes_t  [0:NUM_LANES-1];

   typedef enum logic {
      IDLE = 1'b0,
      READ = 1'b1
   } rd_state_t;

   function automatic mag_t min_mag(input mag_t a, input mag_t b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/cbfp_block_ctrl_if.sv
// Sample-stream bundle between the butterfly output and the next stage input.
interface cbfp_block_ctrl_if;
   import cbfp_pkg::*;

   logic        din_valid;
   din_lanes_t  din_re;
   din_lanes_t  din_im;
   logic        dout_valid;
   dout_lanes_t dout_re;
   dout_lanes_t dout_im;
   mag_t        dout_exp;
   logic        dout_last;

   modport master (
      output din_valid, din_re, din_im,
      input  dout_valid, dout_re, dout_im, dout_exp, dout_last
   );

   modport slave (
      input  din_valid, din_re, din_im,
      output dout_valid, dout_re, dout_im, dout_exp, dout_last
   );

endinterface

// File: rtl/cbfp_mag_detect1.sv
// Per-lane leading-sign count: bits below the sign bit that match it, MSB first.
module cbfp_mag_detect1
   import cbfp_pkg::*;
(
   input  din_lanes_t lanes,
   output mag_lanes_t mags
);

   function automatic mag_t lane_mag(input din_lane_t x);
      mag_t m;
      logic run;
      m   = '0;
      run = 1'b1;
      for (int i = DATA_WIDTH-2; i >= 0; i--) begin
         if (run && (x[i] == x[DATA_WIDTH-1])) begin
            m = m + mag_t'(1);
         end else begin
            run = 1'b0;
         end
      end
      return m;
   endfunction

   always_comb begin
      for (int l = 0; l < NUM_LANES; l++) begin
         mags[l] = lane_mag(lanes[l]);
      end
   end

endmodule

// File: rtl/cbfp_norm_shift.sv
// Eight-lane left barrel shift by the block exponent, truncated to the output width.
module cbfp_norm_shift
   import cbfp_pkg::*;
(
   input  din_lanes_t  lanes,
   input  mag_t        shift,
   output dout_lanes_t norm
);

   din_lanes_t shifted;

   // Exponent never exceeds any lane's own magnitude, so dropping the top bits is lossless.
   always_comb begin
      for (int l = 0; l < NUM_LANES; l++) begin
         shifted[l] = lanes[l] <<< shift;
         norm[l]    = shifted[l][DATA_WIDTH-1 -: OUT_WIDTH];
      end
   end

endmodule

// File: rtl/cbfp_block_ctrl.sv
// Block-floating-point sequencer: ping-pong block buffer with per-block common exponent.
//
// state | meaning
// IDLE  | no block in flight; issues beat 0 as soon as full[rd_bank] is seen
// READ  | streaming beats of rd_bank, one per cycle, rd_cnt = beat being issued
module cbfp_block_ctrl
   import cbfp_pkg::*;
#(
   parameter int BLK_CYC = 2
) (
   input  logic             clk,
   input  logic             rstn,
   cbfp_block_ctrl_if.slave bus
);

   localparam int               CNT_W    = (BLK_CYC > 1) ? $clog2(BLK_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK_CYC - 1);

   mag_lanes_t       mag_re;
   mag_lanes_t       mag_im;
   mag_t             beat_min;

   logic             wr_bank;
   logic [CNT_W-1:0] wr_cnt;
   logic             wr_last;
   mag_t             blk_min [2];
   din_lanes_t       mem_re [2][BLK_CYC];
   din_lanes_t       mem_im [2][BLK_CYC];
   logic [1:0]       full;
   logic [1:0]       full_nxt;

   rd_state_t        state;
   rd_state_t        state_nxt;
   logic             rd_bank;
   logic             rd_bank_nxt;
   logic [CNT_W-1:0] rd_cnt;
   logic [CNT_W-1:0] rd_cnt_nxt;
   logic             rd_issue;
   logic             rd_last;
   din_lanes_t       rd_re;
   din_lanes_t       rd_im;
   dout_lanes_t      norm_re;
   dout_lanes_t      norm_im;

   cbfp_mag_detect1 u_mag_re (.lanes(bus.din_re), .mags(mag_re));
   cbfp_mag_detect1 u_mag_im (.lanes(bus.din_im), .mags(mag_im));

   always_comb begin
      beat_min = mag_re[0];
      for (int l = 0; l < NUM_LANES; l++) begin
         beat_min = min_mag(beat_min, min_mag(mag_re[l], mag_im[l]));
      end
   end

   assign wr_last = bus.din_valid && (wr_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_bank <= 1'b0;
         wr_cnt  <= '0;
         blk_min <= '{default: '0};
      end else if (bus.din_valid) begin
         // First beat of a block seeds the running minimum.
         blk_min[wr_bank] <= (wr_cnt == '0) ? beat_min
                                            : min_mag(blk_min[wr_bank], beat_min);
         if (wr_last) begin
            wr_cnt  <= '0;
            wr_bank <= ~wr_bank;
         end else begin
            wr_cnt  <= wr_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (bus.din_valid) begin
         mem_re[wr_bank][wr_cnt] <= bus.din_re;
         mem_im[wr_bank][wr_cnt] <= bus.din_im;
      end
   end

   always_comb begin
      full_nxt = full;
      if (rd_last) full_nxt[rd_bank] = 1'b0;
      if (wr_last) full_nxt[wr_bank] = 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         full    <= '0;
         state   <= IDLE;
         rd_bank <= 1'b0;
         rd_cnt  <= '0;
      end else begin
         full    <= full_nxt;
         state   <= state_nxt;
         rd_bank <= rd_bank_nxt;
         rd_cnt  <= rd_cnt_nxt;
      end
   end

   // Issuing from IDLE lets a bank that fills on the final read edge follow with no gap.
   always_comb begin
      state_nxt   = state;
      rd_bank_nxt = rd_bank;
      rd_cnt_nxt  = rd_cnt;
      rd_issue    = 1'b0;
      rd_last     = 1'b0;
      case (state)
         IDLE:    rd_issue = full[rd_bank];
         READ:    rd_issue = 1'b1;
         default: rd_issue = 1'b0;
      endcase
      if (rd_issue) begin
         if (rd_cnt == CNT_LAST) begin
            rd_last     = 1'b1;
            rd_cnt_nxt  = '0;
            rd_bank_nxt = ~rd_bank;
            state_nxt   = full[~rd_bank] ? READ : IDLE;
         end else begin
            rd_cnt_nxt  = rd_cnt + CNT_W'(1);
            state_nxt   = READ;
         end
      end
   end

   always_comb begin
      rd_re = mem_re[rd_bank][rd_cnt];
      rd_im = mem_im[rd_bank][rd_cnt];
   end

   cbfp_norm_shift u_norm_re (.lanes(rd_re), .shift(blk_min[rd_bank]), .norm(norm_re));
   cbfp_norm_shift u_norm_im (.lanes(rd_im), .shift(blk_min[rd_bank]), .norm(norm_im));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus.dout_valid <= 1'b0;
         bus.dout_last  <= 1'b0;
         bus.dout_exp   <= '0;
         bus.dout_re    <= '{default: '0};
         bus.dout_im    <= '{default: '0};
      end else begin
         bus.dout_valid <= rd_issue;
         bus.dout_last  <= rd_last;
         if (rd_issue) begin
            bus.dout_exp <= blk_min[rd_bank];
            bus.dout_re  <= norm_re;
            bus.dout_im  <= norm_im;
         end
      end
   end

   a_no_overrun: assert property (@(posedge clk) disable iff (!rstn)
      !(bus.din_valid && full[wr_bank] && !(rd_issue && (rd_bank == wr_bank))));

endmodule

// File: tb/tb_cbfp_block_ctrl.sv
// Randomised bench for cbfp_block_ctrl against a block-level arithmetic reference model.
module tb_cbfp_block_ctrl;
   import cbfp_pkg::*;

   localparam int BLK = 2;

   typedef struct packed {
      int                                    due;
      logic [NUM_LANES-1:0][OUT_WIDTH-1:0]   re;
      logic [NUM_LANES-1:0][OUT_WIDTH-1:0]   im;
      logic [MAG_WIDTH-1:0]                  ex;
      logic                                  last;
   } exp_beat_t;

   logic       clk = 1'b0;
   logic       rstn;
   int         cyc = 0;
   int         n_chk = 0;
   int         n_err = 0;
   exp_beat_t  exp_q [$];
   longint     part_re [BLK][NUM_LANES];
   longint     part_im [BLK][NUM_LANES];
   int         part_n = 0;
   din_lanes_t beat_re;
   din_lanes_t beat_im;

   cbfp_block_ctrl_if bus();

   cbfp_block_ctrl #(.BLK_CYC(BLK)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
      n_chk++;
      if (got !== exp_v) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp_v, cyc);
      end
   endtask

   // Leading-sign count from the bit length of the non-negative image.
   function automatic int ref_mag(input longint v);
      int n;
      n = 0;
      if (v < 0) v = ~v;
      while (v != 0) begin
         n++;
         v = v >> 1;
      end
      return (DATA_WIDTH - 1) - n;
   endfunction

   function automatic logic [OUT_WIDTH-1:0] ref_norm(input longint v, input int e);
      longint p;
      p = v * (longint'(1) << e);
      return OUT_WIDTH'(p >>> (DATA_WIDTH - OUT_WIDTH));
   endfunction

   function automatic din_lane_t rand_val(input int wmax);
      int     w;
      longint v;
      w = $urandom_range(0, wmax);
      v = longint'($urandom) & ((longint'(1) << w) - 1);
      if ($urandom_range(0, 1) == 1) v = -v - 1;
      return din_lane_t'(v);
   endfunction

   task automatic rand_beat(input int wmax);
      for (int l = 0; l < NUM_LANES; l++) begin
         beat_re[l] = rand_val(wmax);
         beat_im[l] = rand_val(wmax);
      end
   endtask

   task automatic fill_const(input din_lane_t v);
      for (int l = 0; l < NUM_LANES; l++) begin
         beat_re[l] = v;
         beat_im[l] = v;
      end
   endtask

   task automatic model_accept(input int sample_edge);
      int        e;
      exp_beat_t x;
      for (int l = 0; l < NUM_LANES; l++) begin
         part_re[part_n][l] = longint'(beat_re[l]);
         part_im[part_n][l] = longint'(beat_im[l]);
      end
      part_n++;
      if (part_n == BLK) begin
         e = DATA_WIDTH - 1;
         for (int b = 0; b < BLK; b++) begin
            for (int l = 0; l < NUM_LANES; l++) begin
               if (ref_mag(part_re[b][l]) < e) e = ref_mag(part_re[b][l]);
               if (ref_mag(part_im[b][l]) < e) e = ref_mag(part_im[b][l]);
            end
         end
         for (int b = 0; b < BLK; b++) begin
            x.due  = sample_edge + 1 + b;
            x.ex   = MAG_WIDTH'(e);
            x.last = (b == BLK - 1);
            for (int l = 0; l < NUM_LANES; l++) begin
               x.re[l] = ref_norm(part_re[b][l], e);
               x.im[l] = ref_norm(part_im[b][l], e);
            end
            exp_q.push_back(x);
         end
         part_n = 0;
      end
   endtask

   task automatic step(input bit v);
      @(posedge clk);
      #1;
      bus.din_valid = v;
      bus.din_re    = beat_re;
      bus.din_im    = beat_im;
      if (v) model_accept(cyc + 1);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, bus.dout_valid, 0);
      chk({tag, "_last"},  bus.dout_last, 0);
      chk({tag, "_exp"},   bus.dout_exp, 0);
      for (int l = 0; l < NUM_LANES; l++) begin
         chk($sformatf("%s_re%0d", tag, l), $unsigned(bus.dout_re[l]), 0);
         chk($sformatf("%s_im%0d", tag, l), $unsigned(bus.dout_im[l]), 0);
      end
   endtask

   task automatic do_reset(input bit busy);
      @(posedge clk);
      #1;
      chk("pre_rst_valid", bus.dout_valid, busy);
      bus.din_valid = 1'b0;
      #1 rstn = 1'b0;
      #1;
      check_zero("mid_rst");
      exp_q.delete();
      part_n = 0;
      repeat (2) @(posedge clk);
      #2 rstn = 1'b1;
   endtask

   always @(negedge clk) begin
      exp_beat_t x;
      if (rstn) begin
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            x = exp_q.pop_front();
            chk("valid", bus.dout_valid, 1);
            chk("exp",   bus.dout_exp, x.ex);
            chk("last",  bus.dout_last, x.last);
            for (int l = 0; l < NUM_LANES; l++) begin
               chk($sformatf("re%0d", l), $unsigned(bus.dout_re[l]), x.re[l]);
               chk($sformatf("im%0d", l), $unsigned(bus.dout_im[l]), x.im[l]);
            end
         end else if (bus.dout_valid) begin
            chk("spurious_valid", bus.dout_valid, 0);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int wmax;
      beat_re       = '{default: '0};
      beat_im       = '{default: '0};
      bus.din_valid = 1'b0;
      bus.din_re    = beat_re;
      bus.din_im    = beat_im;
      rstn          = 1'b1;
      #1 rstn = 1'b0;
      #1;
      check_zero("rst_init");
      repeat (3) @(posedge clk);
      #2 rstn = 1'b1;

      // positive block with one larger lane
      fill_const(25'h000100);
      beat_re[3] = 25'h004000;
      step(1'b1);
      fill_const(25'h000100);
      step(1'b1);
      idle(4);

      // negative block
      fill_const(25'h1FFFF00);
      beat_re[5] = 25'h1FF8000;
      step(1'b1);
      fill_const(25'h1FFFF00);
      step(1'b1);
      idle(4);

      // all-zero block
      fill_const(25'h0);
      step(1'b1);
      step(1'b1);
      idle(4);

      // continuous stream of 4 blocks
      for (int b = 0; b < 4; b++) begin
         wmax = $urandom_range(0, DATA_WIDTH - 1);
         for (int k = 0; k < BLK; k++) begin
            rand_beat(wmax);
            step(1'b1);
         end
      end
      idle(4);

      // 1-in-3 duty cycle
      for (int b = 0; b < 4; b++) begin
         wmax = $urandom_range(0, DATA_WIDTH - 1);
         for (int k = 0; k < BLK; k++) begin
            rand_beat(wmax);
            step(1'b1);
            step(1'b0);
            step(1'b0);
         end
      end
      idle(4);

      // random gaps
      for (int b = 0; b < 10; b++) begin
         wmax = $urandom_range(0, DATA_WIDTH - 1);
         for (int k = 0; k < BLK; k++) begin
            rand_beat(wmax);
            step(1'b1);
            idle($urandom_range(0, 3));
         end
      end
      idle(4);

      // reset mid-fill, then a clean block
      rand_beat(DATA_WIDTH - 1);
      step(1'b1);
      do_reset(1'b0);
      for (int k = 0; k < BLK; k++) begin
         rand_beat(12);
         step(1'b1);
      end
      idle(4);

      // reset mid-readout, then a clean block
      for (int k = 0; k < BLK; k++) begin
         rand_beat(20);
         step(1'b1);
      end
      step(1'b0);
      do_reset(1'b1);
      for (int k = 0; k < BLK; k++) begin
         rand_beat(6);
         step(1'b1);
      end
      idle(2);

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      chk("drain_empty", exp_q.size(), 0);
      repeat (3) @(posedge clk);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
